// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the handshaked data-memory responder.
// MemOp encodings (RISC-V funct3), FSM state codes, LFSR seed/taps and
// an op-legality helper used by dmem_responder and dmem_lane_fmt.
package dmem_pkg;

    // MemOp encodings, identical to the RISC-V load/store funct3 field
    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    // FSM state codes, kept as plain constants for legacy tool flows
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t RESP = 2'd2;

    // Wait counter must hold LATENCY-1 plus up to 7 extra random cycles
    localparam int CNT_W = 5;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Loads accept b/h/w/bu/hu; stores only b/h/w
    function automatic logic op_legal(input logic [2:0] op, input logic wr);
        logic ok;
        case (op)
            MOP_B, MOP_H, MOP_W: ok = 1'b1;
            MOP_BU, MOP_HU:      ok = ~wr;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: combinational byte-lane formatter for one 32-bit word.
// Given the MemOp and the low two offset bits it produces the store byte
// mask, the store data replicated onto the addressed lanes, the extended
// load data picked out of the read word, and a misalignment flag.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  mask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection from the read word; half select ignores off[0] since a
    // misaligned half is flagged as an error and never returned
    always_comb begin
        byte_sel = rword[{off, 3'b000} +: 8];
        half_sel = rword[{off[1], 4'b0000} +: 16];
    end

    // Per-op mask, store replication, load extension and alignment check
    always_comb begin
        mask      = 4'b0000;
        wdata_sh  = 32'h0;
        rdata_ext = 32'h0;
        misalign  = 1'b0;
        case (op)
            MOP_B: begin
                mask      = 4'b0001 << off;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            end
            MOP_BU: begin
                mask      = 4'b0001 << off;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = {24'h0, byte_sel};
            end
            MOP_H: begin
                misalign  = off[0];
                mask      = off[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = {{16{half_sel[15]}}, half_sel};
            end
            MOP_HU: begin
                misalign  = off[0];
                mask      = off[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = {16'h0, half_sel};
            end
            MOP_W: begin
                misalign  = (off != 2'b00);
                mask      = 4'b1111;
                wdata_sh  = wdata;
                rdata_ext = rword;
            end
            default: begin
                mask      = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: target side of the core's load/store interface.
// One request at a time is accepted on a valid/ready channel, held for a
// configurable number of wait cycles, then serviced against an internal
// word array; the result (extended load data or store ack, plus error
// flag) is presented on a valid/ready response channel until taken.
// Optional build macro DMEM_RAND_DELAY_EN adds 0..7 pseudo-random extra
// wait cycles per request from a free-running 16-bit LFSR.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0] BASE       = ADDR_W'(32'h8000_0000),
    parameter int                LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wr,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int                WORDS = 1 << DEPTH_LOG2;
    localparam logic [ADDR_W:0]   SPAN  = (ADDR_W + 1)'(4) << DEPTH_LOG2;
    localparam logic [CNT_W-1:0]  LAT_C = CNT_W'(LATENCY);

    // Control state
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             armed;

    // Captured request
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        op_q;
    logic              wr_q;
    logic [31:0]       wdata_q;

    // Request currently being serviced (live inputs in IDLE for LATENCY==0)
    logic [ADDR_W-1:0]     cur_addr;
    logic [2:0]            cur_op;
    logic                  cur_wr;
    logic [31:0]           cur_wdata;
    logic [ADDR_W-1:0]     cur_off;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  oor;
    logic                  err;

    logic        accept;
    logic        enter_resp;
    logic [CNT_W-1:0] wait_len;

    logic [31:0] mem [0:WORDS-1];
    logic [31:0] rword;
    logic [3:0]  mask;
    logic [31:0] wdata_sh;
    logic [31:0] rdata_ext;
    logic        misalign;

    assign req_ready  = armed && (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;

`ifdef DMEM_RAND_DELAY_EN
    logic [15:0] lfsr;

    // Free-running LFSR; its low three bits stretch each request's wait
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign wait_len = LAT_C + CNT_W'(lfsr[2:0]);
`else
    assign wait_len = LAT_C;
`endif

    // Select which request drives decode: live bus while idle, capture otherwise
    always_comb begin
        if (state == IDLE) begin
            cur_addr  = req_addr;
            cur_op    = req_op;
            cur_wr    = req_wr;
            cur_wdata = req_wdata;
        end else begin
            cur_addr  = addr_q;
            cur_op    = op_q;
            cur_wr    = wr_q;
            cur_wdata = wdata_q;
        end
    end

    // Address decode relative to BASE; wrap-around below BASE lands out of range
    always_comb begin
        cur_off  = cur_addr - BASE;
        word_idx = cur_off[DEPTH_LOG2+1:2];
        oor      = ({1'b0, cur_off} >= SPAN);
        rword    = mem[word_idx];
    end

    dmem_lane_fmt u_lane_fmt (
        .op        (cur_op),
        .off       (cur_off[1:0]),
        .wdata     (cur_wdata),
        .rword     (rword),
        .mask      (mask),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext),
        .misalign  (misalign)
    );

    assign err = misalign || !op_legal(cur_op, cur_wr) || oor;

    // Next-state and wait-counter logic
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (wait_len == '0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = wait_len - CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control registers and the response holding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            armed      <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            armed <= 1'b1;
            if (enter_resp) begin
                resp_err   <= err;
                resp_rdata <= (err || cur_wr) ? 32'h0 : rdata_ext;
            end
        end
    end

    // Capture the accepted request; held unchanged until the next acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            op_q    <= req_op;
            wr_q    <= req_wr;
            wdata_q <= req_wdata;
        end
    end

    // Byte-lane store into the array on the edge that enters RESP
    always_ff @(posedge clk) begin
        if (enter_resp && cur_wr && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder (default
// parameters). A byte-addressed reference memory computes every expected
// load/store result from the MemOp rules; directed scenarios cover the
// documented cases and a randomized phase covers the rest.
module tb_dmem_responder;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          LAT    = 2;
    localparam int unsigned SPAN_B = 4 << 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        req_wr = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] mem_b [int unsigned];

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wr     (req_wr),
        .req_op     (req_op),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    // Reference: byte memory, sizes from op[1:0], sign from op[2]
    function automatic void model_access(input logic [31:0] a, input logic w,
                                         input logic [2:0] op, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic er);
        int unsigned off;
        int unsigned size;
        bit          legal;
        longint unsigned v;
        off = a - BASE;
        case (op[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        legal = (size != 0) && !(op[2] && op[1]) && !(w && op[2]);
        er = !legal || (off >= SPAN_B);
        if (legal && (off % size) != 0) er = 1'b1;
        rd = 32'h0;
        if (er) return;
        if (w) begin
            for (int i = 0; i < size; i++) mem_b[off + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < size; i++)
                if (mem_b.exists(off + i)) v = v | (longint'(mem_b[off + i]) << (8*i));
            if (!op[2] && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 1);
            rd = v[31:0];
        end
    endfunction

    function automatic bit lat_ok(input int lat);
`ifdef DMEM_RAND_DELAY_EN
        return (lat >= LAT + 1) && (lat <= LAT + 8);
`else
        return lat == LAT + 1;
`endif
    endfunction

    // Drive one transaction; stall = cycles resp_ready is held low after resp_valid
    task automatic do_op(input logic [31:0] a, input logic w, input logic [2:0] op,
                         input logic [31:0] wd, input int stall,
                         output logic [31:0] rd, output logic er, output int lat,
                         output bit ok, output bit stable,
                         output logic [31:0] m_rd, output logic m_er);
        int n;
        model_access(a, w, op, wd, m_rd, m_er);
        ok = 1'b1; stable = 1'b1; lat = 0; rd = 32'h0; er = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_wr = w; req_op = op; req_wdata = wd;
        resp_ready = (stall == 0);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin req_valid = 1'b0; resp_ready = 1'b1; ok = 1'b0; return; end
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_op = 3'($urandom);
        do begin @(negedge clk); lat++; end while (!resp_valid && lat < 50);
        if (!resp_valid) begin resp_ready = 1'b1; ok = 1'b0; return; end
        rd = resp_rdata; er = resp_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0)
                stable = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        if (resp_valid !== 1'b0) stable = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        compared++;
        if ({req_ready, resp_valid, resp_err} !== 3'b000 || resp_rdata !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rdata=%h required 0/0/0/0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_release_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, m_rd; logic er, m_er; int lat; bit ok, st;
        do_op(BASE + 32'h10, 1'b1, 3'b010, 32'hDEADBEEF, 0, rd, er, lat, ok, st, m_rd, m_er);
        compared++;
        if (!ok || er !== 1'b0 || rd !== 32'h0 || !lat_ok(lat)) begin
            mismatched++;
            $display("FAIL sw_basic: got ok=%0d err=%b rdata=%h lat=%0d required 1/0/0/%0d", ok, er, rd, lat, LAT+1);
        end
        do_op(BASE + 32'h10, 1'b0, 3'b010, 32'h0, 0, rd, er, lat, ok, st, m_rd, m_er);
        compared++;
        if (!ok || er !== 1'b0 || rd !== 32'hDEADBEEF || !lat_ok(lat)) begin
            mismatched++;
            $display("FAIL lw_basic: got ok=%0d err=%b rdata=%h lat=%0d required 1/0/deadbeef/%0d", ok, er, rd, lat, LAT+1);
        end
    endtask

    task automatic test_subword();
        logic [31:0] addrs [4] = '{BASE + 32'h13, BASE + 32'h13, BASE + 32'h10, BASE + 32'h12};
        logic [2:0]  ops   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
        logic [31:0] rd, m_rd; logic er, m_er; int lat; bit ok, st;
        for (int i = 0; i < 4; i++) begin
            do_op(addrs[i], 1'b0, ops[i], 32'h0, 0, rd, er, lat, ok, st, m_rd, m_er);
            compared++;
            if (!ok || er !== 1'b0 || rd !== exps[i] || rd !== m_rd) begin
                mismatched++;
                $display("FAIL subword_%0d: got ok=%0d err=%b rdata=%h required rdata=%h", i, ok, er, rd, exps[i]);
            end
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd, m_rd; logic er, m_er; int lat; bit ok, st;
        do_op(BASE + 32'h11, 1'b1, 3'b000, 32'h00000012, 0, rd, er, lat, ok, st, m_rd, m_er);
        do_op(BASE + 32'h10, 1'b0, 3'b010, 32'h0, 0, rd, er, lat, ok, st, m_rd, m_er);
        compared++;
        if (!ok || er !== 1'b0 || rd !== 32'hDEAD12EF) begin
            mismatched++;
            $display("FAIL sb_lane: got ok=%0d err=%b rdata=%h required deadf12ef->dead12ef", ok, er, rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, m_rd; logic er, m_er; int lat; bit ok, st;
        do_op(BASE + 32'h12, 1'b0, 3'b010, 32'h0, 0, rd, er, lat, ok, st, m_rd, m_er);
        compared++;
        if (!ok || er !== 1'b1 || rd !== 32'h0 || !lat_ok(lat)) begin
            mismatched++;
            $display("FAIL err_lw_misalign: got ok=%0d err=%b rdata=%h lat=%0d required 1/1/0", ok, er, rd, lat);
        end
        do_op(BASE, 1'b1, 3'b010, 32'h11111111, 0, rd, er, lat, ok, st, m_rd, m_er);
        do_op(BASE + 32'h4, 1'b1, 3'b010, 32'h22222222, 0, rd, er, lat, ok, st, m_rd, m_er);
        do_op(32'h7FFFFFFC, 1'b1, 3'b010, 32'h99999999, 0, rd, er, lat, ok, st, m_rd, m_er);
        compared++;
        if (!ok || er !== 1'b1 || rd !== 32'h0) begin
            mismatched++;
            $display("FAIL err_sw_oor: got ok=%0d err=%b rdata=%h required 1/1/0", ok, er, rd);
        end
        do_op(BASE, 1'b0, 3'b010, 32'h0, 0, rd, er, lat, ok, st, m_rd, m_er);
        compared++;
        if (!ok || er !== 1'b0 || rd !== 32'h11111111) begin
            mismatched++;
            $display("FAIL err_neighbour0: got err=%b rdata=%h required 0/11111111", er, rd);
        end
        do_op(BASE + 32'h4, 1'b0, 3'b010, 32'h0, 0, rd, er, lat, ok, st, m_rd, m_er);
        compared++;
        if (!ok || er !== 1'b0 || rd !== 32'h22222222) begin
            mismatched++;
            $display("FAIL err_neighbour1: got err=%b rdata=%h required 0/22222222", er, rd);
        end
        do_op(BASE + 32'h10, 1'b0, 3'b011, 32'h0, 0, rd, er, lat, ok, st, m_rd, m_er);
        compared++;
        if (!ok || er !== 1'b1 || rd !== 32'h0) begin
            mismatched++;
            $display("FAIL err_op011: got err=%b rdata=%h required 1/0", er, rd);
        end
        do_op(BASE + 32'h10, 1'b1, 3'b100, 32'h55, 0, rd, er, lat, ok, st, m_rd, m_er);
        compared++;
        if (!ok || er !== 1'b1) begin
            mismatched++;
            $display("FAIL err_store_op100: got err=%b required 1", er);
        end
        do_op(BASE + SPAN_B, 1'b0, 3'b010, 32'h0, 0, rd, er, lat, ok, st, m_rd, m_er);
        compared++;
        if (!ok || er !== 1'b1 || rd !== 32'h0) begin
            mismatched++;
            $display("FAIL err_lw_top: got err=%b rdata=%h required 1/0", er, rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] m_rd, rd; logic m_er, er; bit stable; int n;
        model_access(BASE + 32'h10, 1'b0, 3'b010, 32'h0, m_rd, m_er);
        @(negedge clk);
        req_valid = 1'b1; req_addr = BASE + 32'h10; req_wr = 1'b0; req_op = 3'b010;
        resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_addr = BASE + 32'h14;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 50);
        rd = resp_rdata; er = resp_err;
        compared++;
        if (resp_valid !== 1'b1 || rd !== m_rd || er !== m_er) begin
            mismatched++;
            $display("FAIL bp_first: got vld=%b rdata=%h err=%b required 1/%h/%b", resp_valid, rd, er, m_rd, m_er);
        end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0)
                stable = 1'b0;
        end
        compared++;
        if (!stable) begin
            mismatched++;
            $display("FAIL bp_hold: got vld=%b rdata=%h rdy=%b required 1/%h/0", resp_valid, resp_rdata, req_ready, rd);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_release: got vld=%b rdy=%b required 0/1", resp_valid, req_ready);
        end
        stable = 1'b1;
        repeat (6) begin @(negedge clk); if (resp_valid !== 1'b0) stable = 1'b0; end
        compared++;
        if (!stable) begin
            mismatched++;
            $display("FAIL bp_no_accept: got vld=1 required 0 (request during stall taken)");
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd, m_rd; logic er, m_er; int lat; bit ok, st, quiet; int n;
        @(negedge clk);
        req_valid = 1'b1; req_addr = BASE + 32'h10; req_wr = 1'b1; req_op = 3'b010;
        req_wdata = 32'hCAFEF00D; resp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        compared++;
        if ({req_ready, resp_valid, resp_err} !== 3'b000 || resp_rdata !== 32'h0) begin
            mismatched++;
            $display("FAIL rst_async: got rdy=%b vld=%b err=%b rdata=%h required 0/0/0/0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        quiet = 1'b1;
        repeat (3) begin @(negedge clk); if (resp_valid !== 1'b0) quiet = 1'b0; end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_ready_after: got %b required 1", req_ready);
        end
        repeat (5) begin @(negedge clk); if (resp_valid !== 1'b0) quiet = 1'b0; end
        compared++;
        if (!quiet) begin
            mismatched++;
            $display("FAIL rst_no_resp: got resp_valid=1 required 0");
        end
        do_op(BASE + 32'h10, 1'b0, 3'b010, 32'h0, 0, rd, er, lat, ok, st, m_rd, m_er);
        compared++;
        if (!ok || er !== 1'b0 || rd !== 32'hDEAD12EF || rd !== m_rd) begin
            mismatched++;
            $display("FAIL rst_store_dropped: got ok=%0d rdata=%h required dead12ef", ok, rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, m_rd, a; logic er, m_er; int lat; bit ok, st;
        logic [2:0] op; logic w;
        for (int i = 0; i < 16; i++) begin
            do_op(BASE + 32'(4*i), 1'b1, 3'b010, $urandom, 0, rd, er, lat, ok, st, m_rd, m_er);
            compared++;
            if (!ok || er !== 1'b0) begin
                mismatched++;
                $display("FAIL rand_preload_%0d: got ok=%0d err=%b required 1/0", i, ok, er);
            end
        end
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 7))
                0:       a = BASE - 32'($urandom_range(1, 8));
                1:       a = BASE + SPAN_B + 32'($urandom_range(0, 7));
                default: a = BASE + 32'($urandom_range(0, 63));
            endcase
            op = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            do_op(a, w, op, $urandom, $urandom_range(0, 3), rd, er, lat, ok, st, m_rd, m_er);
            compared++;
            if (!ok || !st || !lat_ok(lat) || rd !== m_rd || er !== m_er) begin
                mismatched++;
                $display("FAIL rand_%0d a=%h wr=%b op=%b: got ok=%0d stable=%0d lat=%0d rdata=%h err=%b required rdata=%h err=%b",
                         i, a, w, op, ok, st, lat, rd, er, m_rd, m_er);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_subword();
        test_byte_store();
        test_errors();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
